shift_add_multiplier: RTL

//  Unsigned sequential M x M multiplier built on the codebase ripple_adder.

---
 rtl/shift_add_multiplier_pkg.sv | 24 ++
 rtl/ripple_adder.sv | 36 +++
 rtl/shift_add_multiplier.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/shift_add_multiplier_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_add_multiplier_pkg
//  Description : Shared state encodings and width helper for the sequential
//                shift-and-add multiplier.
//  Contents    : state_t (ST_IDLE / ST_RUN / ST_DONE), cnt_width()
//  Revision    : 1.0 - initial release
// ============================================================================
package shift_add_multiplier_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Iteration counter width. The extra bit keeps the counter wide enough
    // to hold M itself even when M is a power of two.
    function automatic int cnt_width(input int m);
        return $clog2(m) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ripple_adder.sv
`default_nettype none
// ============================================================================
//  Module      : ripple_adder
//  Description : m-bit ripple-carry adder built from a chain of full adders.
//  Ports       : i_a, i_b  [m-1:0]  addends
//                i_cin              carry in
//                o_sum     [m-1:0]  sum
//                o_cout             carry out of the top bit
//  Revision    : 1.0 - initial release
// ============================================================================
module ripple_adder #(
    parameter int m = 4
) (
    input  logic [m-1:0] i_a,
    input  logic [m-1:0] i_b,
    input  logic         i_cin,
    output logic [m-1:0] o_sum,
    output logic         o_cout
);

    logic [m:0] w_carry;

    assign w_carry[0] = i_cin;

    generate
        for (genvar gi = 0; gi < m; gi++) begin : g_bit
            assign o_sum[gi]     = i_a[gi] ^ i_b[gi] ^ w_carry[gi];
            assign w_carry[gi+1] = (i_a[gi] & i_b[gi]) |
                                   (w_carry[gi] & (i_a[gi] ^ i_b[gi]));
        end
    endgenerate

    assign o_cout = w_carry[m];

endmodule
`default_nettype wire

// File: rtl/shift_add_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : shift_add_multiplier
//  Description : Unsigned sequential M x M multiplier. Each RUN cycle adds the
//                multiplicand into the upper partial product when the current
//                multiplier LSB is set, then shifts {carry,P,Q} right by one.
//                After M iterations {P,Q} holds the 2M-bit product.
//  Ports       : clk            rising-edge clock
//                rst_n          asynchronous active-low reset
//                start          request a multiply (accepted in IDLE only)
//                a, b  [M-1:0]  operands, sampled on the accepting edge
//                busy           high while iterating
//                done           one-cycle pulse, product valid
//                product [2M-1:0] result, held until the next accepted start
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_add_multiplier #(
    parameter int M = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [M-1:0]     a,
    input  logic [M-1:0]     b,
    output logic             busy,
    output logic             done,
    output logic [2*M-1:0]   product
);

    import shift_add_multiplier_pkg::*;

    localparam int CW = cnt_width(M);
    localparam logic [CW-1:0] c_CNT_LAST = CW'(M - 1);

    state_t         r_state;
    state_t         w_state_nxt;

    logic [M-1:0]   r_a;
    logic [M-1:0]   r_p;
    logic [M-1:0]   r_q;
    logic [CW-1:0]  r_cnt;
    logic [2*M-1:0] r_product;

    logic [M-1:0]   w_sum;
    logic           w_cout;
    logic [M-1:0]   w_p_nxt;
    logic [M-1:0]   w_q_nxt;
    logic           w_load;
    logic           w_step;
    logic           w_last;

    // Partial product plus multiplicand; only used when the multiplier LSB
    // is set, otherwise the unmodified partial product is shifted.
    ripple_adder #(.m(M)) u_adder (
        .i_a    (r_p),
        .i_b    (r_a),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // The carry-out becomes the new P MSB, so the add can never overflow.
    always_comb begin
        if (r_q[0]) begin
            w_p_nxt = {w_cout, w_sum[M-1:1]};
            w_q_nxt = {w_sum[0], r_q[M-1:1]};
        end else begin
            w_p_nxt = {1'b0, r_p[M-1:1]};
            w_q_nxt = {r_p[0], r_q[M-1:1]};
        end
    end

    assign w_last = (r_cnt == c_CNT_LAST);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy   = 1'b1;
                w_step = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_p       <= '0;
            r_q       <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_load) begin
            r_a   <= a;
            r_q   <= b;
            r_p   <= '0;
            r_cnt <= '0;
        end else if (w_step) begin
            r_p   <= w_p_nxt;
            r_q   <= w_q_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_product <= {w_p_nxt, w_q_nxt};
            end
        end
    end

    assign product = r_product;

endmodule
`default_nettype wire
